sipo_deframer: RTL and testbench
================================

# sipo_deframer

Serial-in, parallel-out receiver that consumes an LSB-first serial bit stream (the output format of our 4-bit parallel-load serializer) and reassembles it into WIDTH-bit words. Framing is acquired from a start-of-word strobe. Completed words are presented on a one-entry output register with a valid/ready handshake. It is the stage directly downstream of the serializer and feeds any parallel consumer.

## Interface
- WIDTH, default 4: data bits per word (legal range 2..16).
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- Serial_IN  input  1  serial data bit, LSB first.
- Serial_EN  input  1  Serial_IN is valid this cycle; bits are ignored when low.
- Frame_Start  input  1  qualified by Serial_EN; marks the current bit as bit 0 of a word.
- Par_OUT  output  WIDTH  assembled word.
- Out_Valid  output  1  Par_OUT holds an unconsumed word.
- Out_Ready  input  1  consumer accepts Par_OUT when Out_Valid & Out_Ready.
- Overrun  output  1  one-cycle pulse: a completed word was dropped.
- Frame_Err  output  1  one-cycle pulse: Frame_Start arrived mid-word.
- Parity_Err  output  1  parity flag for Par_OUT; see Configuration.

## Operation
- FSM states:
  - HUNT (reset state).
  - SHIFT.
  - PAR (exists only with parity compiled in).
- HUNT:
  - A bit with Serial_EN=1 and Frame_Start=0 is discarded.
  - A bit with Serial_EN=1 and Frame_Start=1 is stored as bit 0; count becomes 1; go to SHIFT.
- SHIFT:
  - Each Serial_EN=1 bit is stored at position count; count increments.
  - When bit WIDTH-1 is accepted, the word is complete. Without parity, count resets to 0 and the FSM stays in SHIFT; the next enabled bit is bit 0 of the next word and needs no Frame_Start.
- Frame_Start=1 with Serial_EN=1 while count≠0:
  - Discard the partial word.
  - Store the current bit as bit 0; count becomes 1.
  - Pulse Frame_Err.
- Frame_Start at count=0 is legal and raises no error.
- Serial_EN=0 holds all state; Frame_Start is ignored.
- Word completion:
  - If Out_Valid=0, or Out_Valid=1 and Out_Ready=1 in the same cycle, load Par_OUT and set Out_Valid.
  - Otherwise drop the new word, keep Par_OUT, and pulse Overrun.
- Out_Valid & Out_Ready with no completing word: clear Out_Valid. Par_OUT keeps its last value.
- Reset values: Par_OUT=0, Out_Valid=0, Overrun=0, Frame_Err=0, Parity_Err=0, FSM=HUNT, count=0.
- Reset asserted mid-word discards the partial word and any pending output. After release, the block waits in HUNT for Frame_Start.

## Timing
- Latency: last bit sampled at edge N → Par_OUT/Out_Valid valid after edge N. Same for the parity bit when parity is compiled in.
- Throughput: one word per WIDTH enabled bits (WIDTH+1 with parity); back-to-back words are supported.
- Overrun and Frame_Err assert for exactly one cycle, after the same edge that caused them.
- Par_OUT is stable while Out_Valid=1 and Out_Ready=0.

## Configuration
- Macro SIPO_DEFRAMER_PARITY_EN.
- Defined:
  - After bit WIDTH-1 the FSM enters PAR.
  - The next enabled bit is an even-parity bit over the data bits.
  - On that bit the word completes; Parity_Err is loaded alongside Par_OUT and is high if the XOR of data and parity is 1. The word is still delivered.
  - Frame_Start in PAR is a mid-word Frame_Start (Frame_Err, restart at bit 0).
- Undefined: the PAR state is absent; Parity_Err is tied to 0.

## Structure
- Package sipo_pkg holds:
  - The FSM state typedef (HUNT, SHIFT, PAR).
  - The counter-width constant function (clog2 of WIDTH+1).
- One sub-module, sipo_out_reg: the one-entry Par_OUT/Parity_Err holding register with valid/ready and overrun detection.
- The top level holds the FSM, the counter and the shift register.

## Test plan
- WIDTH=4, Out_Ready=1. Frame_Start with bit 0, then serial bits 1,0,1,1 on consecutive enabled cycles → Par_OUT=4'hD, Out_Valid high for one cycle after the 4th bit.
- In HUNT, bits 1,1,1 without Frame_Start → no Out_Valid; then a framed 0,1,0,0 → Par_OUT=4'h2.
- Frame_Start after 2 bits of a word → Frame_Err pulse; the following 4 bits 1,1,1,1 → Par_OUT=4'hF.
- Out_Ready=0 and two back-to-back words 4'h3 then 4'h9 → Par_OUT stays 4'h3, Overrun pulses on completion of 4'h9; Out_Ready=1 → Out_Valid clears.
- RST_N low after 2 bits, then released → all outputs 0; the next 4 unframed bits are ignored.
- SIPO_DEFRAMER_PARITY_EN defined: data 1,0,1,1 with parity 1 → Par_OUT=4'hD, Parity_Err=0; with parity 0 → Parity_Err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deframer.
// Build option SIPO_DEFRAMER_PARITY_EN enables the trailing even-parity bit.
package sipo_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Bit count register must hold 0..WIDTH (WIDTH marks the parity slot)
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial input side and parallel valid/ready output side of the deframer.
interface sipo_deframer_if #(
  parameter int unsigned WIDTH = 4
);

  logic             Serial_IN;
  logic             Serial_EN;
  logic             Frame_Start;
  logic             Out_Ready;
  logic [WIDTH-1:0] Par_OUT;
  logic             Out_Valid;
  logic             Overrun;
  logic             Frame_Err;
  logic             Parity_Err;

  modport master (
    output Serial_IN, Serial_EN, Frame_Start, Out_Ready,
    input  Par_OUT, Out_Valid, Overrun, Frame_Err, Parity_Err
  );

  modport slave (
    input  Serial_IN, Serial_EN, Frame_Start, Out_Ready,
    output Par_OUT, Out_Valid, Overrun, Frame_Err, Parity_Err
  );

endinterface

// File: rtl/sipo_out_reg.sv
// One-entry output holding register with valid/ready and overrun pulse.
module sipo_out_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_err_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             par_err_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             par_err_q, par_err_d;
  logic             overrun_q, overrun_d;
  logic             accept_c;

  // A new word may replace the entry only if it is empty or drained this cycle
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    par_err_d = par_err_q;
    overrun_d = 1'b0;
    accept_c  = !valid_q || ready_i;
    if (load_i) begin
      if (accept_c) begin
        data_d    = data_i;
        par_err_d = par_err_i;
        valid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      par_err_q <= par_err_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign par_err_o = par_err_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/sipo_deframer.sv
// LSB-first serial to WIDTH-bit word deframer with start-strobe framing.
// Define SIPO_DEFRAMER_PARITY_EN to expect a trailing even-parity bit per word.
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  sipo_deframer_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] mask_c;
  logic             word_done_c;
  logic [WIDTH-1:0] word_c;
  logic             par_err_c;

  // Framing FSM: bit counter and shift register advance only on enabled bits
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    word_done_c = 1'b0;
    word_c      = shreg_q;
    par_err_c   = 1'b0;
    mask_c      = WIDTH'(1) << cnt_q;
    if (bus.Serial_EN) begin
      if (bus.Frame_Start) begin
        // Non-zero count means a word (or its parity bit) is still open
        frame_err_d = (cnt_q != '0);
        shreg_d     = {{(WIDTH-1){1'b0}}, bus.Serial_IN};
        cnt_d       = CW'(1);
        state_d     = SHIFT;
      end else begin
        case (state_q)
          SHIFT: begin
            shreg_d = bus.Serial_IN ? (shreg_q | mask_c) : (shreg_q & ~mask_c);
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SIPO_DEFRAMER_PARITY_EN
              cnt_d   = CW'(WIDTH);
              state_d = PAR;
`else
              cnt_d       = '0;
              word_done_c = 1'b1;
              word_c      = shreg_d;
`endif
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
`ifdef SIPO_DEFRAMER_PARITY_EN
          PAR: begin
            word_done_c = 1'b1;
            word_c      = shreg_q;
            par_err_c   = ^{shreg_q, bus.Serial_IN};
            cnt_d       = '0;
            state_d     = SHIFT;
          end
`endif
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= HUNT;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .load_i    (word_done_c),
    .data_i    (word_c),
    .par_err_i (par_err_c),
    .ready_i   (bus.Out_Ready),
    .data_o    (bus.Par_OUT),
    .valid_o   (bus.Out_Valid),
    .par_err_o (bus.Parity_Err),
    .overrun_o (bus.Overrun)
  );

  assign bus.Frame_Err = frame_err_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Testbench for sipo_deframer: directed vector table plus randomized run vs a bit-queue model.
module tb_sipo_deframer;

  localparam int unsigned WIDTH = 4;
`ifdef SIPO_DEFRAMER_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sipo_deframer_if #(.WIDTH(WIDTH)) bus();

  sipo_deframer #(.WIDTH(WIDTH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             rst;
    bit             en;
    bit             fs;
    bit             sin;
    bit             rdy;
    logic [WIDTH-1:0] data;
    bit             valid;
    bit             ovr;
    bit             ferr;
    bit             perr;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: bits collected since the last frame start / word boundary
  bit               mq[$];
  bit               framed;
  logic [WIDTH-1:0] m_data;
  bit               m_valid, m_perr, m_ovr, m_ferr;

  function automatic void model_reset();
    mq.delete();
    framed  = 1'b0;
    m_data  = '0;
    m_valid = 1'b0;
    m_perr  = 1'b0;
    m_ovr   = 1'b0;
    m_ferr  = 1'b0;
  endfunction

  function automatic void model_step(input bit en, input bit fs, input bit sin, input bit rdy);
    bit               done = 1'b0;
    logic [WIDTH-1:0] w    = '0;
    bit               p    = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
    if (en) begin
      if (fs) begin
        m_ferr = (mq.size() != 0);
        mq.delete();
        mq.push_back(sin);
        framed = 1'b1;
      end else if (framed) begin
        mq.push_back(sin);
        if (mq.size() == FL) begin
          for (int i = 0; i < int'(WIDTH); i++) w[i] = mq[i];
`ifdef SIPO_DEFRAMER_PARITY_EN
          for (int i = 0; i < FL; i++) p = p ^ mq[i];
`endif
          done = 1'b1;
          mq.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_perr  = p;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endfunction

  function automatic void add(input bit rst, input bit en, input bit fs, input bit sin,
                              input bit rdy, input logic [WIDTH-1:0] d, input bit v,
                              input bit o, input bit f, input bit p);
    vec_t r;
    r.rst = rst; r.en = en; r.fs = fs; r.sin = sin; r.rdy = rdy;
    r.data = d; r.valid = v; r.ovr = o; r.ferr = f; r.perr = p;
    tbl.push_back(r);
  endfunction

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge
  task automatic cycle(input bit rst, input bit en, input bit fs, input bit sin, input bit rdy);
    bus.Serial_EN   = en;
    bus.Frame_Start = fs;
    bus.Serial_IN   = sin;
    bus.Out_Ready   = rdy;
    if (rst) begin
      rst_n = 1'b0;
      model_reset();
    end else begin
      model_step(en, fs, sin, rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [WIDTH+3:0] exp);
    logic [WIDTH+3:0] act;
    act = {bus.Par_OUT, bus.Out_Valid, bus.Overrun, bus.Frame_Err, bus.Parity_Err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual {data,valid,ovr,ferr,perr}=%h,%b%b%b%b required=%h,%b%b%b%b",
               name, act[WIDTH+3:4], act[3], act[2], act[1], act[0],
               exp[WIDTH+3:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    bus.Serial_EN   = 1'b0;
    bus.Frame_Start = 1'b0;
    bus.Serial_IN   = 1'b0;
    bus.Out_Ready   = 1'b0;
    model_reset();

`ifdef SIPO_DEFRAMER_PARITY_EN
    // word D with good parity, word D with bad parity, Frame_Start in PAR, word E
    add(0,1,1,1,1, 4'h0,0,0,0,0);
    add(0,1,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'hD,1,0,0,0);
    add(0,1,0,1,1, 4'hD,0,0,0,0);
    add(0,1,0,0,1, 4'hD,0,0,0,0);
    add(0,1,0,1,1, 4'hD,0,0,0,0);
    add(0,1,0,1,1, 4'hD,0,0,0,0);
    add(0,1,0,0,1, 4'hD,1,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,1,0,1, 4'hD,0,0,1,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hD,0,0,0,1);
    add(0,1,0,1,1, 4'hE,1,0,0,0);
    add(1,0,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,0,1,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
`else
    // framed D
    add(0,1,1,1,1, 4'h0,0,0,0,0);
    add(0,1,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'hD,1,0,0,0);
    add(0,0,0,0,1, 4'hD,0,0,0,0);
    // back to HUNT: unframed bits ignored, then framed 2
    add(1,0,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,1,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,0,1, 4'h2,1,0,0,0);
    // mid-word Frame_Start, then F
    add(0,1,0,1,1, 4'h2,0,0,0,0);
    add(0,1,0,1,1, 4'h2,0,0,0,0);
    add(0,1,1,1,1, 4'h2,0,0,1,0);
    add(0,1,0,1,1, 4'h2,0,0,0,0);
    add(0,1,0,1,1, 4'h2,0,0,0,0);
    add(0,1,0,1,1, 4'hF,1,0,0,0);
    add(0,0,0,0,1, 4'hF,0,0,0,0);
    // stalled consumer: 3 held, 9 dropped with Overrun
    add(0,1,1,1,0, 4'hF,0,0,0,0);
    add(0,1,0,1,0, 4'hF,0,0,0,0);
    add(0,1,0,0,0, 4'hF,0,0,0,0);
    add(0,1,0,0,0, 4'h3,1,0,0,0);
    add(0,1,0,1,0, 4'h3,1,0,0,0);
    add(0,1,0,0,0, 4'h3,1,0,0,0);
    add(0,1,0,0,0, 4'h3,1,0,0,0);
    add(0,1,0,1,0, 4'h3,1,1,0,0);
    add(0,0,0,0,0, 4'h3,1,0,0,0);
    add(0,0,0,0,1, 4'h3,0,0,0,0);
    // reset mid-word; unframed bits and un-enabled Frame_Start ignored afterwards
    add(0,1,1,1,1, 4'h3,0,0,0,0);
    add(0,1,0,1,1, 4'h3,0,0,0,0);
    add(1,0,0,0,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
    add(0,0,1,1,1, 4'h0,0,0,0,0);
    add(0,1,0,1,1, 4'h0,0,0,0,0);
`endif

    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset", '0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].en, tbl[i].fs, tbl[i].sin, tbl[i].rdy);
      check($sformatf("dir%0d", i),
            {tbl[i].data, tbl[i].valid, tbl[i].ovr, tbl[i].ferr, tbl[i].perr});
      rst_n = 1'b1;
    end

    for (int n = 0; n < 3000; n++) begin
      bit rst, en, fs, sin, rdy;
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 3) != 0);
      fs  = ($urandom_range(0, 9) == 0);
      sin = 1'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(rst, en, fs, sin, rdy);
      check($sformatf("rnd%0d", n), {m_data, m_valid, m_ovr, m_ferr, m_perr});
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
